// File: rtl/reduce_result_collector.sv
// Collects completed reduction results (ivalid && ilast) into a FIFO; ready/valid output, drops+flags when full.
// Latency: push at edge N -> ovalid/odata after edge N (registered head). Optional drop counter: REDUCE_COLLECTOR_DROPCNT_EN.
// Backpressure: oready stalls the output only; upstream never stalls, so results arriving while full are dropped.

module reduce_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;

  assign rd_nxt = rd_ptr_q + AW'(1);

  // Head register mirrors mem[rd_ptr] so odata never comes straight from the input.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_nxt;
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (pop && (count_q > (AW+1)'(1))) begin
        head_d = mem_q[rd_nxt];
      end else if (push && ((count_q == '0) || pop)) begin
        head_d = wdat;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign rdat  = head_q;
  assign count = count_q;

endmodule

module reduce_result_collector #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ivalid,
  input  logic [WIDTH-1:0]  idata,
  input  logic              ilast,
  input  logic              clr,
  output logic [WIDTH-1:0]  odata,
  output logic              ovalid,
  input  logic              oready,
  output logic [AWIDTH:0]   count,
`ifdef REDUCE_COLLECTOR_DROPCNT_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              overflow
);

  typedef enum logic {
    S_EMPTY    = 1'b0,
    S_NONEMPTY = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   overflow_q, overflow_d;
  logic   push_req, push_ok, pop, full, drop;

  assign push_req = ivalid && ilast;
  assign pop      = ovalid && oready;
  assign full     = (count == (AWIDTH+1)'(DEPTH));
  // clr wins over everything: a push in the clr cycle is neither stored nor counted as a drop.
  assign push_ok  = push_req && !clr && (!full || pop);
  assign drop     = push_req && !clr && full && !pop;

  reduce_result_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AWIDTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr),
    .push  (push_ok),
    .pop   (pop),
    .wdat  (idata),
    .rdat  (odata),
    .count (count)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
    case (state_q)
      S_EMPTY: begin
        if (push_ok) begin
          state_d = S_NONEMPTY;
        end
      end
      S_NONEMPTY: begin
        if (clr) begin
          state_d = S_EMPTY;
        end else if (pop && !push_ok && (count == (AWIDTH+1)'(1))) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_EMPTY;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign ovalid   = (state_q == S_NONEMPTY);
  assign overflow = overflow_q;

`ifdef REDUCE_COLLECTOR_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_reduce_result_collector.sv
// Directed table-driven bench for reduce_result_collector plus reducer-flow and non-last sequences.
module tb_reduce_result_collector;

  logic        CLK = 1'b0;
  logic        RST, ivalid, ilast, clr, oready;
  logic [31:0] idata, odata;
  logic        ovalid, overflow;
  logic [2:0]  count;
`ifdef REDUCE_COLLECTOR_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  reduce_result_collector #(.WIDTH(32), .DEPTH(4), .AWIDTH(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ivalid   (ivalid),
    .idata    (idata),
    .ilast    (ilast),
    .clr      (clr),
    .odata    (odata),
    .ovalid   (ovalid),
    .oready   (oready),
    .count    (count),
`ifdef REDUCE_COLLECTOR_DROPCNT_EN
    .drop_cnt (drop_cnt),
`endif
    .overflow (overflow)
  );

  typedef struct {
    logic        rst, iv, il, clr, ordy;
    logic [31:0] id;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] dat;
    logic        ovf;
    logic [15:0] drp;
  } vec_t;

  vec_t vt[32];

  function automatic vec_t v(input logic rst, iv, il, input logic [31:0] id, input logic cl, ordy,
                             input logic [2:0] cnt, input logic vld, input logic [31:0] dat,
                             input logic ovf, input logic [15:0] drp);
    vec_t r;
    r.rst = rst; r.iv = iv; r.il = il; r.id = id; r.clr = cl; r.ordy = ordy;
    r.cnt = cnt; r.vld = vld; r.dat = dat; r.ovf = ovf; r.drp = drp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic rst, iv, il, input logic [31:0] id, input logic cl, ordy);
    RST = rst; ivalid = iv; ilast = il; idata = id; clr = cl; oready = ordy;
  endtask

  int acc;
  int grp;
  int exp_sum [4] = '{360, 1128, 1896, 2664};

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    //          rst iv il id     clr ordy  cnt vld dat  ovf drp
    vt[0]  = v(1, 0, 0, 32'd0,   0, 0,    0, 0, 0,   0, 0);
    vt[1]  = v(0, 1, 0, 32'd99,  0, 0,    0, 0, 0,   0, 0);
    vt[2]  = v(0, 1, 1, 32'd10,  0, 0,    1, 1, 10,  0, 0);
    vt[3]  = v(0, 1, 1, 32'd20,  0, 0,    2, 1, 10,  0, 0);
    vt[4]  = v(0, 1, 1, 32'd30,  0, 0,    3, 1, 10,  0, 0);
    vt[5]  = v(0, 1, 1, 32'd40,  0, 0,    4, 1, 10,  0, 0);
    vt[6]  = v(0, 1, 1, 32'd50,  0, 0,    4, 1, 10,  1, 1);
    vt[7]  = v(0, 0, 0, 32'd0,   0, 1,    3, 1, 20,  1, 1);
    vt[8]  = v(0, 0, 0, 32'd0,   0, 1,    2, 1, 30,  1, 1);
    vt[9]  = v(0, 1, 1, 32'd60,  0, 0,    3, 1, 30,  1, 1);
    vt[10] = v(1, 0, 0, 32'd0,   0, 0,    0, 0, 0,   0, 0);
    vt[11] = v(0, 1, 1, 32'd70,  0, 0,    1, 1, 70,  0, 0);
    vt[12] = v(0, 1, 1, 32'd80,  0, 1,    1, 1, 80,  0, 0);
    vt[13] = v(0, 1, 1, 32'd90,  0, 0,    2, 1, 80,  0, 0);
    vt[14] = v(0, 1, 1, 32'd100, 0, 0,    3, 1, 80,  0, 0);
    vt[15] = v(0, 1, 1, 32'd110, 0, 0,    4, 1, 80,  0, 0);
    vt[16] = v(0, 1, 1, 32'd120, 0, 1,    4, 1, 90,  0, 0);
    vt[17] = v(0, 0, 0, 32'd0,   0, 1,    3, 1, 100, 0, 0);
    vt[18] = v(0, 0, 0, 32'd0,   0, 1,    2, 1, 110, 0, 0);
    vt[19] = v(0, 0, 0, 32'd0,   0, 1,    1, 1, 120, 0, 0);
    vt[20] = v(0, 1, 1, 32'd130, 0, 0,    2, 1, 120, 0, 0);
    vt[21] = v(0, 1, 1, 32'd140, 1, 1,    0, 0, 0,   0, 0);
    vt[22] = v(0, 0, 0, 32'd0,   0, 1,    0, 0, 0,   0, 0);
    vt[23] = v(0, 1, 1, -32'sd5, 0, 0,    1, 1, -32'sd5, 0, 0);
    vt[24] = v(0, 1, 1, 32'd1,   0, 0,    2, 1, -32'sd5, 0, 0);
    vt[25] = v(0, 1, 1, 32'd2,   0, 0,    3, 1, -32'sd5, 0, 0);
    vt[26] = v(0, 1, 1, 32'd3,   0, 0,    4, 1, -32'sd5, 0, 0);
    vt[27] = v(0, 1, 1, 32'd4,   0, 0,    4, 1, -32'sd5, 1, 1);
    vt[28] = v(0, 0, 0, 32'd0,   1, 0,    0, 0, 0,   0, 0);
    vt[29] = v(0, 0, 1, 32'd7,   0, 0,    0, 0, 0,   0, 0);
    vt[30] = v(0, 1, 1, 32'd8,   0, 1,    1, 1, 8,   0, 0);
    vt[31] = v(0, 0, 0, 32'd0,   0, 1,    0, 0, 0,   0, 0);

    repeat (2) @(posedge CLK);

    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      drive(vt[i].rst, vt[i].iv, vt[i].il, vt[i].id, vt[i].clr, vt[i].ordy);
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("row%0d ovalid", i), 32'(ovalid), 32'(vt[i].vld));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vt[i].ovf));
      if (vt[i].vld || vt[i].rst)
        chk($sformatf("row%0d odata", i), odata, vt[i].dat);
`ifdef REDUCE_COLLECTOR_DROPCNT_EN
      chk($sformatf("row%0d drop_cnt", i), 32'(drop_cnt), 32'(vt[i].drp));
`endif
    end

    // Long run of non-last beats must never enqueue anything.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      drive(1'b0, 1'b1, 1'b0, 32'(i * 7 + 1), 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      chk($sformatf("nonlast%0d count", i), 32'(count), 32'd0);
      chk($sformatf("nonlast%0d ovalid", i), 32'(ovalid), 32'd0);
    end

    // Reducer flow: x=0..63, y=2x, groups of 16; accumulated x+y presented each beat.
    acc = 0;
    grp = 0;
    for (int x = 0; x < 64; x++) begin
      @(negedge CLK);
      acc = acc + x + 2 * x;
      drive(1'b0, 1'b1, ((x % 16) == 15), 32'(acc), 1'b0, 1'b1);
      @(posedge CLK);
      #1;
      total++;
      if (count > 3'd1) begin
        bad++;
        $display("FAIL flow%0d count: got %0d expected <=1", x, count);
      end
      if ((x % 16) == 15) begin
        chk($sformatf("flow grp%0d ovalid", grp), 32'(ovalid), 32'd1);
        chk($sformatf("flow grp%0d odata", grp), odata, 32'(exp_sum[grp]));
        grp++;
        acc = 0;
      end
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk("flow drained count", 32'(count), 32'd0);
    chk("flow drained ovalid", 32'(ovalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
